// File: rtl/otter_decode_stage.sv
// OTTER decode stage: full RV32I decode into a registered ID/EX word, load-use bubbles, CSR drain.
// Optional M-extension decode is enabled by defining OTTER_MEXT_EN.
module otter_decode_stage #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            if_valid,
  input  logic [31:0]     if_ir,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            hazard_stall,
  output logic            de_valid,
  output logic [XLEN-1:0] de_pc,
  output logic [4:0]      de_rs1,
  output logic [4:0]      de_rs2,
  output logic [4:0]      de_rd,
  output logic [3:0]      de_alu_fun,
  output logic [1:0]      de_alu_srcA,
  output logic [2:0]      de_alu_srcB,
  output logic [1:0]      de_rf_wr_sel,
  output logic            de_regWrite,
  output logic            de_memWrEn,
  output logic            de_memRdEn,
  output logic            de_csr_we,
  output logic            de_mret_ex,
  output logic            de_jump,
  output logic            de_illegal,
  output logic            de_mul_en,
  output logic [2:0]      de_pcSource,
  output logic [2:0]      de_mul_op
);

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] alu_srcA;
    logic [2:0] alu_srcB;
    logic [1:0] rf_wr_sel;
    logic       regWrite;
    logic       memWrEn;
    logic       memRdEn;
    logic       csr_we;
    logic       mret_ex;
    logic       jump;
    logic       illegal;
    logic       mul_en;
    logic [2:0] pcSource;
    logic [2:0] mul_op;
  } ctl_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUI = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JLR = 7'b1100111;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_CPB  = 4'b1001;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_opc = if_ir[6:0];
  assign w_f3  = if_ir[14:12];
  assign w_f7  = if_ir[31:25];
  assign w_rs1 = if_ir[19:15];
  assign w_rs2 = if_ir[24:20];
  assign w_rd  = if_ir[11:7];

  logic w_is_lui, w_is_aui, w_is_jal, w_is_jlr, w_is_br;
  logic w_is_ld, w_is_st, w_is_imm, w_is_op, w_is_sys;

  assign w_is_lui = (w_opc == OPC_LUI);
  assign w_is_aui = (w_opc == OPC_AUI);
  assign w_is_jal = (w_opc == OPC_JAL);
  assign w_is_jlr = (w_opc == OPC_JLR);
  assign w_is_br  = (w_opc == OPC_BR);
  assign w_is_ld  = (w_opc == OPC_LD);
  assign w_is_st  = (w_opc == OPC_ST);
  assign w_is_imm = (w_opc == OPC_IMM);
  assign w_is_op  = (w_opc == OPC_OP);
  assign w_is_sys = (w_opc == OPC_SYS);

  logic w_f7_std;
  logic w_shamt;

  assign w_f7_std = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
  assign w_shamt  = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  ctl_t w_dec;
  logic w_ill;

  always_comb begin
    w_dec = '0;
    w_ill = 1'b0;
    unique case (1'b1)
      w_is_lui: begin
        w_dec.alu_fun   = ALU_CPB;
        w_dec.alu_srcA  = 2'b01;
        w_dec.rf_wr_sel = 2'b11;
        w_dec.regWrite  = 1'b1;
      end
      w_is_aui: begin
        w_dec.alu_srcA  = 2'b01;
        w_dec.alu_srcB  = 3'b011;
        w_dec.rf_wr_sel = 2'b11;
        w_dec.regWrite  = 1'b1;
      end
      w_is_jal: begin
        w_dec.pcSource = 3'b011;
        w_dec.regWrite = 1'b1;
        w_dec.jump     = 1'b1;
      end
      w_is_jlr: begin
        w_dec.pcSource = 3'b001;
        w_dec.regWrite = 1'b1;
        w_dec.jump     = 1'b1;
      end
      w_is_ld: begin
        w_dec.alu_srcB  = 3'b001;
        w_dec.rf_wr_sel = 2'b10;
        w_dec.memRdEn   = 1'b1;
        w_dec.regWrite  = 1'b1;
      end
      w_is_st: begin
        w_dec.alu_srcB = 3'b010;
        w_dec.memWrEn  = 1'b1;
      end
      w_is_br: begin
        unique case (w_f3)
          3'b010, 3'b011: w_ill = 1'b1;
          3'b110, 3'b111: w_dec.alu_fun = ALU_SLTU;
          default:        w_dec.alu_fun = ALU_SLT;
        endcase
      end
      w_is_imm: begin
        if (w_shamt && !w_f7_std)
          w_ill = 1'b1;
        // only SRAI uses bit 30 as an op select
        w_dec.alu_fun   = {(w_f3 == 3'b101) && if_ir[30], w_f3};
        w_dec.alu_srcB  = 3'b001;
        w_dec.rf_wr_sel = 2'b11;
        w_dec.regWrite  = 1'b1;
      end
      w_is_op: begin
        if (w_f7_std) begin
          w_dec.alu_fun = {if_ir[30] &&
                           ((w_f3 == 3'b000) || (w_f3 == 3'b101)),
                           w_f3};
          w_dec.rf_wr_sel = 2'b11;
          w_dec.regWrite  = 1'b1;
        end
`ifdef OTTER_MEXT_EN
        else if (w_f7 == 7'b0000001) begin
          w_dec.mul_en    = 1'b1;
          w_dec.mul_op    = w_f3;
          w_dec.rf_wr_sel = 2'b11;
          w_dec.regWrite  = 1'b1;
        end
`endif
        else
          w_ill = 1'b1;
      end
      w_is_sys: begin
        unique case (w_f3)
          3'b000: w_dec.mret_ex = 1'b1;
          3'b001: begin
            w_dec.alu_fun   = ALU_CPB;
            w_dec.rf_wr_sel = 2'b01;
            w_dec.csr_we    = 1'b1;
            w_dec.regWrite  = 1'b1;
          end
          3'b010: begin
            w_dec.alu_fun   = ALU_OR;
            w_dec.rf_wr_sel = 2'b01;
            w_dec.csr_we    = 1'b1;
            w_dec.regWrite  = 1'b1;
          end
          3'b011: begin
            w_dec.alu_fun   = ALU_AND;
            w_dec.alu_srcA  = 2'b10;
            w_dec.rf_wr_sel = 2'b01;
            w_dec.csr_we    = 1'b1;
            w_dec.regWrite  = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  logic w_use1;
  logic w_use2;
  logic w_sys;

  assign w_use2 = w_is_br | w_is_st | w_is_op;
  assign w_use1 = w_use2 | w_is_imm | w_is_ld | w_is_jlr |
                  (w_is_sys & (w_f3 != 3'b000));
  assign w_sys  = w_is_sys & ~w_f3[2];

  ctl_t            r_de;
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;

  logic w_hit;

  assign w_hit = (w_use1 && (w_rs1 == r_rd)) ||
                 (w_use2 && (w_rs2 == r_rd));
  assign hazard_stall = if_valid & r_valid & r_de.memRdEn &
                        (r_rd != 5'd0) & w_hit;

  state_t     r_state;
  state_t     w_nstate;
  logic [3:0] r_cnt;
  logic [3:0] w_ncnt;
  logic       w_take;

  assign w_take = if_valid & id_ready & ~flush & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (flush) begin
      w_nstate = S_RUN;
      w_ncnt   = 4'd0;
    end else if (ex_ready) begin
      unique case (r_state)
        S_RUN: begin
          if (w_take && w_sys) begin
            w_nstate = S_DRAIN;
            w_ncnt   = CNT_INIT;
          end
        end
        S_DRAIN: begin
          if (r_cnt == 4'd0)
            w_nstate = S_RUN;
          else
            w_ncnt = r_cnt - 4'd1;
        end
        default: w_nstate = S_RUN;
      endcase
    end
  end

  always_comb begin
    id_ready = 1'b0;
    if (RST)
      id_ready = 1'b0;
    else if (flush)
      id_ready = 1'b1;
    else if (r_state == S_RUN)
      id_ready = ex_ready & ~hazard_stall;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_rd    <= 5'd0;
      r_de    <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_pc    <= if_pc;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_rd    <= w_rd;
      r_de    <= w_dec;
    end else if (flush || ex_ready) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_rd    <= 5'd0;
      r_de    <= '0;
    end
  end

  assign de_valid     = r_valid;
  assign de_pc        = r_pc;
  assign de_rs1       = r_rs1;
  assign de_rs2       = r_rs2;
  assign de_rd        = r_rd;
  assign de_alu_fun   = r_de.alu_fun;
  assign de_alu_srcA  = r_de.alu_srcA;
  assign de_alu_srcB  = r_de.alu_srcB;
  assign de_rf_wr_sel = r_de.rf_wr_sel;
  assign de_regWrite  = r_de.regWrite;
  assign de_memWrEn   = r_de.memWrEn;
  assign de_memRdEn   = r_de.memRdEn;
  assign de_csr_we    = r_de.csr_we;
  assign de_mret_ex   = r_de.mret_ex;
  assign de_jump      = r_de.jump;
  assign de_illegal   = r_de.illegal;
  assign de_mul_en    = r_de.mul_en;
  assign de_pcSource  = r_de.pcSource;
  assign de_mul_op    = r_de.mul_op;

endmodule

// File: tb/tb_otter_decode_stage.sv
// Bench for otter_decode_stage: directed scenarios plus random traffic against a behavioural model.
// Build with OTTER_MEXT_EN defined to exercise the M-extension decode.
module tb_otter_decode_stage;

  localparam int DC = 2;

  typedef struct packed {
    logic [3:0] fun;
    logic [1:0] srcA;
    logic [2:0] srcB;
    logic [1:0] wsel;
    logic       rw, mw, mr, csr, mret, jmp, ill, mul;
    logic [2:0] pcs;
    logic [2:0] mop;
    logic [4:0] rs1, rs2, rd;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_ir = 32'h0;
  logic [31:0] if_pc = 32'h0;
  logic        ex_ready = 1'b1;
  logic        flush = 1'b0;
  logic        id_ready, hazard_stall, de_valid;
  logic [31:0] de_pc;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic [3:0]  de_alu_fun;
  logic [1:0]  de_alu_srcA, de_rf_wr_sel;
  logic [2:0]  de_alu_srcB, de_pcSource, de_mul_op;
  logic        de_regWrite, de_memWrEn, de_memRdEn, de_csr_we;
  logic        de_mret_ex, de_jump, de_illegal, de_mul_en;

  int n_checks = 0;
  int n_fail = 0;

  otter_decode_stage #(.XLEN(32), .DRAIN_CYCLES(DC)) dut (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_ir(if_ir),
    .if_pc(if_pc), .id_ready(id_ready), .ex_ready(ex_ready),
    .flush(flush), .hazard_stall(hazard_stall), .de_valid(de_valid),
    .de_pc(de_pc), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
    .de_alu_fun(de_alu_fun), .de_alu_srcA(de_alu_srcA),
    .de_alu_srcB(de_alu_srcB), .de_rf_wr_sel(de_rf_wr_sel),
    .de_regWrite(de_regWrite), .de_memWrEn(de_memWrEn),
    .de_memRdEn(de_memRdEn), .de_csr_we(de_csr_we),
    .de_mret_ex(de_mret_ex), .de_jump(de_jump),
    .de_illegal(de_illegal), .de_mul_en(de_mul_en),
    .de_pcSource(de_pcSource), .de_mul_op(de_mul_op)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [2:0] f3,
                                        input logic alt);
    if (alt && f3 == 3'd0) return 4'd8;
    if (alt && f3 == 3'd5) return 4'd13;
    return {1'b0, f3};
  endfunction

  function automatic exp_t mdec(input logic [31:0] ir);
    exp_t e;
    logic bad;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic std;
    op = ir[6:0];
    f3 = ir[14:12];
    f7 = ir[31:25];
    std = (f7 == 7'h00) || (f7 == 7'h20);
    e = '0;
    bad = 1'b0;
    case (op)
      7'h37: begin e.fun = 4'd9; e.srcA = 2'd1; e.wsel = 2'd3; e.rw = 1; end
      7'h17: begin e.srcA = 2'd1; e.srcB = 3'd3; e.wsel = 2'd3; e.rw = 1; end
      7'h6f: begin e.pcs = 3'd3; e.rw = 1; e.jmp = 1; end
      7'h67: begin e.pcs = 3'd1; e.rw = 1; e.jmp = 1; end
      7'h03: begin e.srcB = 3'd1; e.wsel = 2'd2; e.mr = 1; e.rw = 1; end
      7'h23: begin e.srcB = 3'd2; e.mw = 1; end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) bad = 1;
        else e.fun = (f3 >= 3'd6) ? 4'd3 : 4'd2;
      end
      7'h13: begin
        if ((f3 == 3'd1 || f3 == 3'd5) && !std) bad = 1;
        e.fun = alu_of(f3, f3 == 3'd5 && ir[30]);
        e.srcB = 3'd1; e.wsel = 2'd3; e.rw = 1;
      end
      7'h33: begin
        if (std) begin
          e.fun = alu_of(f3, f7 == 7'h20);
          e.wsel = 2'd3; e.rw = 1;
        end
`ifdef OTTER_MEXT_EN
        else if (f7 == 7'h01) begin
          e.mul = 1; e.mop = f3; e.wsel = 2'd3; e.rw = 1;
        end
`endif
        else bad = 1;
      end
      7'h73: begin
        case (f3)
          3'd0: e.mret = 1;
          3'd1: begin e.fun = 4'd9; e.wsel = 2'd1; e.csr = 1; e.rw = 1; end
          3'd2: begin e.fun = 4'd6; e.wsel = 2'd1; e.csr = 1; e.rw = 1; end
          3'd3: begin
            e.fun = 4'd7; e.srcA = 2'd2; e.wsel = 2'd1; e.csr = 1; e.rw = 1;
          end
          default: bad = 1;
        endcase
      end
      default: bad = 1;
    endcase
    if (bad) begin
      e = '0;
      e.ill = 1;
    end
    e.rs1 = ir[19:15];
    e.rs2 = ir[24:20];
    e.rd  = ir[11:7];
    return e;
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ir);
    case (ir[6:0])
      7'h13, 7'h03, 7'h67, 7'h63, 7'h23, 7'h33: return 1'b1;
      7'h73: return ir[14:12] != 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    return ir[6:0] == 7'h63 || ir[6:0] == 7'h23 || ir[6:0] == 7'h33;
  endfunction

  function automatic logic is_sys(input logic [31:0] ir);
    return ir[6:0] == 7'h73 && ir[14:12] <= 3'd3;
  endfunction

  logic        m_known = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'h0;
  exp_t        m_e = '0;
  int          m_drain = 0;

  always @(negedge CLK) begin
    exp_t a;
    logic m_haz;
    logic m_idr;
    a = '{de_alu_fun, de_alu_srcA, de_alu_srcB, de_rf_wr_sel,
          de_regWrite, de_memWrEn, de_memRdEn, de_csr_we, de_mret_ex,
          de_jump, de_illegal, de_mul_en, de_pcSource, de_mul_op,
          de_rs1, de_rs2, de_rd};
    m_haz = if_valid && m_valid && m_e.mr && m_e.rd != 5'd0 &&
            ((uses_rs1(if_ir) && if_ir[19:15] == m_e.rd) ||
             (uses_rs2(if_ir) && if_ir[24:20] == m_e.rd));
    if (RST) m_idr = 1'b0;
    else if (flush) m_idr = 1'b1;
    else m_idr = (m_drain == 0) && ex_ready && !m_haz;
    if (m_known) begin
      chk("de_valid", 64'(de_valid), 64'(m_valid));
      chk("de_pc", 64'(de_pc), 64'(m_pc));
      chk("de_word", 64'(a), 64'(m_e));
      chk("hazard_stall", 64'(hazard_stall), 64'(m_haz));
      chk("id_ready", 64'(id_ready), 64'(m_idr));
    end
    if (RST || flush) begin
      m_known = 1'b1;
      m_valid = 1'b0; m_pc = '0; m_e = '0; m_drain = 0;
    end else if (ex_ready) begin
      if (m_drain > 0) begin
        m_drain--;
        m_valid = 1'b0; m_pc = '0; m_e = '0;
      end else if (if_valid && !m_haz) begin
        m_valid = 1'b1; m_pc = if_pc; m_e = mdec(if_ir);
        if (is_sys(if_ir)) m_drain = DC;
      end else begin
        m_valid = 1'b0; m_pc = '0; m_e = '0;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] op;
    logic [6:0] f7;
    case ($urandom_range(0, 10))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6f;  3: op = 7'h67;
      4: op = 7'h03;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h13;
      8: op = 7'h33;  9: op = 7'h73;  default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
      3: f7 = 7'h00;  default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW5  = 32'h00012283;
  localparam logic [31:0] ADD6 = 32'h00128333;
  localparam logic [31:0] LW0  = 32'h00012003;
  localparam logic [31:0] ADD0 = 32'h00100333;
  localparam logic [31:0] CSRW = 32'h305110F3;
  localparam logic [31:0] MUL  = 32'h022081B3;

  initial begin
    exp_t p;
    p = mdec(ADDI);
    chk("pin_addi_model", 64'({p.fun, p.srcB, p.rw, p.rd}),
        64'({4'd0, 3'd1, 1'b1, 5'd1}));
    p = mdec(CSRW);
    chk("pin_csrrw_model", 64'({p.fun, p.wsel, p.csr, p.rw}),
        64'({4'd9, 2'd1, 1'b1, 1'b1}));

    RST = 1'b1;
    #1;
    chk("rst_id_ready", 64'(id_ready), 64'(0));
    cyc(); cyc();
    chk("rst_de_valid", 64'(de_valid), 64'(0));
    chk("rst_de_pc", 64'(de_pc), 64'(0));
    RST = 1'b0;

    if_valid = 1'b1; if_ir = ADDI; if_pc = 32'h100; ex_ready = 1'b1;
    #1;
    chk("addi_id_ready", 64'(id_ready), 64'(1));
    cyc();
    chk("addi_de", 64'({de_valid, de_alu_fun, de_alu_srcB, de_regWrite, de_rd}),
        64'({1'b1, 4'd0, 3'd1, 1'b1, 5'd1}));

    if_ir = LW5; if_pc = 32'h104;
    cyc();
    if_ir = ADD6; if_pc = 32'h108;
    #1;
    chk("lu_hazard", 64'(hazard_stall), 64'(1));
    chk("lu_id_ready", 64'(id_ready), 64'(0));
    cyc();
    chk("lu_bubble", 64'(de_valid), 64'(0));
    chk("lu_after_ready", 64'(id_ready), 64'(1));
    cyc();
    chk("lu_add_issued", 64'({de_valid, de_rd, de_pc}),
        64'({1'b1, 5'd6, 32'h108}));

    if_ir = LW0; if_pc = 32'h10c;
    cyc();
    if_ir = ADD0; if_pc = 32'h110;
    #1;
    chk("x0_no_hazard", 64'(hazard_stall), 64'(0));
    cyc();
    chk("x0_add_issued", 64'(de_valid), 64'(1));

    if_ir = CSRW; if_pc = 32'h114;
    cyc();
    chk("csr_issue", 64'({de_valid, de_csr_we, de_rf_wr_sel, de_alu_fun}),
        64'({1'b1, 1'b1, 2'd1, 4'd9}));
    if_ir = ADDI; if_pc = 32'h118;
    for (int i = 0; i < DC; i++) begin
      #1;
      chk("drain_id_ready", 64'(id_ready), 64'(0));
      cyc();
      chk("drain_bubble", 64'(de_valid), 64'(0));
    end
    chk("drain_done_ready", 64'(id_ready), 64'(1));
    cyc();
    chk("drain_next_issue", 64'({de_valid, de_pc}), 64'({1'b1, 32'h118}));

    if_ir = CSRW; if_pc = 32'h11c;
    cyc();
    if_ir = ADDI; if_pc = 32'h120; flush = 1'b1;
    #1;
    chk("flush_id_ready", 64'(id_ready), 64'(1));
    cyc();
    flush = 1'b0;
    chk("flush_kill", 64'(de_valid), 64'(0));
    if_pc = 32'h124;
    #1;
    chk("flush_run_ready", 64'(id_ready), 64'(1));
    cyc();
    chk("flush_next_issue", 64'({de_valid, de_pc}), 64'({1'b1, 32'h124}));

    ex_ready = 1'b0; if_ir = LW5; if_pc = 32'h128;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_id_ready", 64'(id_ready), 64'(0));
      cyc();
      chk("hold_de", 64'({de_valid, de_pc, de_rd, de_alu_srcB}),
          64'({1'b1, 32'h124, 5'd1, 3'd1}));
    end
    ex_ready = 1'b1;

    if_ir = MUL; if_pc = 32'h12c;
    cyc();
    cyc();
    if_ir = MUL; if_pc = 32'h130;
    cyc();
`ifdef OTTER_MEXT_EN
    chk("mul_ext", 64'({de_mul_en, de_mul_op, de_regWrite, de_illegal}),
        64'({1'b1, 3'd0, 1'b1, 1'b0}));
`else
    chk("mul_illegal", 64'({de_illegal, de_regWrite, de_mul_en}),
        64'({1'b1, 1'b0, 1'b0}));
`endif

    for (int i = 0; i < 4000; i++) begin
      RST      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      if_valid = ($urandom_range(0, 5) != 0);
      if_ir    = rand_ir();
      if_pc    = $urandom;
      cyc();
    end
    RST = 1'b0; flush = 1'b0; if_valid = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
